spi_bus_arbiter: RTL and testbench

- Shares the single SPI bus (flash and SD card pins) between two requesters: port A (boot/ROM loader, high priority) and port B (CPU-side SPI port).
- Grants whole sessions, drives both chip selects, and sequences byte transfers through an internal mode-0 shifter.
- Sits between the machine core and the board's flash_*/sd_* pins and drives the activity LED.

---
 rtl/spi_arb_pkg.sv | 18 +
 rtl/spi_byte_shifter.sv | 76 +++++++
 rtl/spi_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI bus arbiter: arbitration states, device codes and default divider.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B,
    RELEASE
  } arb_state_e;

  typedef enum logic {
    DEV_FLASH = 1'b0,
    DEV_SD    = 1'b1
  } dev_e;

  localparam int unsigned CLKDIV_DEFAULT = 2;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine, MSB first: sclk divider, 8-bit shift register and edge counter.
module spi_byte_shifter #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] txd_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic [7:0] rxd_o,
  output logic       busy_o,
  output logic       done_o
);

  logic [7:0] div_q;
  logic [3:0] edge_q;
  logic [7:0] sh_q;
  logic [7:0] rxd_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       busy_q;
  logic       done_q;
  logic       tick;

  assign tick = busy_q && (div_q == 8'(CLKDIV - 1));

  // One register carries both directions: tx bits leave at the top while rx bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      edge_q <= '0;
      sh_q   <= '0;
      rxd_q  <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start_i) begin
          busy_q <= 1'b1;
          sh_q   <= txd_i;
          mosi_q <= txd_i[7];
          div_q  <= '0;
          edge_q <= '0;
        end
      end else if (tick) begin
        div_q  <= '0;
        edge_q <= edge_q + 4'd1;
        sclk_q <= ~sclk_q;
        if (!sclk_q) begin
          sh_q <= {sh_q[6:0], miso_i};
        end else if (edge_q == 4'd15) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          rxd_q  <= sh_q;
          mosi_q <= 1'b1;
        end else begin
          mosi_q <= sh_q[7];
        end
      end else begin
        div_q <= div_q + 8'd1;
      end
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign rxd_o  = rxd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Session arbiter for the shared flash/SD SPI bus; port A outranks port B, no preemption.
// ACTIVITY_LED_EN adds a LED_HOLD-bit stretch counter on testled.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLKDIV = CLKDIV_DEFAULT
`ifdef ACTIVITY_LED_EN
  ,
  parameter int unsigned LED_HOLD = 20
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  input  logic       dev_a,
  input  logic       dev_b,
  input  logic       cs_a,
  input  logic       cs_b,
  input  logic       start_a,
  input  logic       start_b,
  input  logic [7:0] txd_a,
  input  logic [7:0] txd_b,
  output logic [7:0] rxd,
  output logic       busy,
  output logic       done_a,
  output logic       done_b,
  output logic       flash_cs_n,
  output logic       sd_cs_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       testled
);

  arb_state_e state_q;
  dev_e       owner_dev_q;
  logic       gnt_a_q;
  logic       gnt_b_q;
  logic       flash_cs_n_q;
  logic       sd_cs_n_q;

  logic       own_b;
  logic       own_any;
  logic       own_req;
  logic       own_cs;
  logic       own_start;
  logic       sh_start;
  logic       sh_done;
  logic [7:0] sh_txd;

  assign own_b     = (state_q == OWN_B);
  assign own_any   = (state_q == OWN_A) || own_b;
  assign own_req   = own_b ? req_b   : req_a;
  assign own_cs    = own_b ? cs_b    : cs_a;
  assign own_start = own_b ? start_b : start_a;
  assign sh_txd    = own_b ? txd_b   : txd_a;
  assign sh_start  = own_any && own_req && own_start && !busy;

  // The state cannot leave OWN_x while a byte is in flight, so it still names the owner at done.
  assign done_a = sh_done && (state_q == OWN_A);
  assign done_b = sh_done && own_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_dev_q  <= DEV_FLASH;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      flash_cs_n_q <= 1'b1;
      sd_cs_n_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_a) begin
            state_q     <= OWN_A;
            gnt_a_q     <= 1'b1;
            owner_dev_q <= dev_e'(dev_a);
          end else if (req_b) begin
            state_q     <= OWN_B;
            gnt_b_q     <= 1'b1;
            owner_dev_q <= dev_e'(dev_b);
          end
        end
        OWN_A, OWN_B: begin
          if (!own_req && !busy) begin
            state_q      <= RELEASE;
            flash_cs_n_q <= 1'b1;
            sd_cs_n_q    <= 1'b1;
          end else begin
            flash_cs_n_q <= !(own_cs && (owner_dev_q == DEV_FLASH));
            sd_cs_n_q    <= !(own_cs && (owner_dev_q == DEV_SD));
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign flash_cs_n = flash_cs_n_q;
  assign sd_cs_n    = sd_cs_n_q;

  spi_byte_shifter #(
    .CLKDIV(CLKDIV)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(sh_start),
    .txd_i  (sh_txd),
    .miso_i (spi_miso),
    .sclk_o (spi_clk),
    .mosi_o (spi_mosi),
    .rxd_o  (rxd),
    .busy_o (busy),
    .done_o (sh_done)
  );

`ifdef ACTIVITY_LED_EN
  logic [LED_HOLD-1:0] led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else if (!flash_cs_n_q || !sd_cs_n_q) begin
      led_q <= '1;
    end else if (led_q != '0) begin
      led_q <= led_q - LED_HOLD'(1);
    end
  end

  assign testled = (led_q != '0);
`else
  assign testled = ~flash_cs_n_q | ~sd_cs_n_q;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a cycle-indexed reference model and literal spot checks.
module tb_spi_bus_arbiter;

  localparam int D = 2;
`ifdef ACTIVITY_LED_EN
  localparam int LH = 4;
  localparam bit STRETCH = 1'b1;
  localparam int LED_MAX = 15;
  localparam int EXP_HOLD = 15;
`else
  localparam bit STRETCH = 1'b0;
  localparam int LED_MAX = 0;
  localparam int EXP_HOLD = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, dev_a = 1'b0, dev_b = 1'b0;
  logic cs_a = 1'b0, cs_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [7:0] txd_a = 8'h00, txd_b = 8'h00;
  logic [7:0] rxd;
  logic gnt_a, gnt_b, busy, done_a, done_b, flash_cs_n, sd_cs_n;
  logic spi_clk, spi_mosi, spi_miso, testled;
  logic loop = 1'b1;

  assign spi_miso = loop ? spi_mosi : 1'b0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .CLKDIV(D)
`ifdef ACTIVITY_LED_EN
    , .LED_HOLD(LH)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .dev_a(dev_a), .dev_b(dev_b), .cs_a(cs_a), .cs_b(cs_b),
    .start_a(start_a), .start_b(start_b), .txd_a(txd_a), .txd_b(txd_b),
    .rxd(rxd), .busy(busy), .done_a(done_a), .done_b(done_b),
    .flash_cs_n(flash_cs_n), .sd_cs_n(sd_cs_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .testled(testled)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, {gnt_a, gnt_b}, 0);
    chk({tag, "_cs_n"}, {flash_cs_n, sd_cs_n}, 2'b11);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, {done_a, done_b}, 0);
    chk({tag, "_rxd"}, rxd, 0);
    chk({tag, "_clk_mosi"}, {spi_clk, spi_mosi}, 2'b01);
    chk({tag, "_led"}, testled, 0);
  endtask

  // Reference model: session ownership plus the timestamp of the accepted byte.
  int cyc = 0;
  int m_phase = 0;      // 0 bus free, 1 session open, 2 closing (chip selects already high)
  int m_own = 0;        // 0 none, 1 port A, 2 port B
  bit m_dev = 1'b0;
  bit e_gnt_a = 1'b0, e_gnt_b = 1'b0, e_fcs = 1'b1, e_scs = 1'b1;
  bit x_live = 1'b0;
  int x_t0 = 0;
  int x_who = 0;
  logic [7:0] x_tx = 8'h00, x_rx = 8'h00, m_rxd = 8'h00;
  int prev_low = -1000;
  int done_a_cnt = 0, done_b_cnt = 0, rises = 0;

  always @(posedge spi_clk) rises++;

  always @(posedge clk) begin
    int c;
    bit bz, rq, cx, st;
    c = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_phase = 0; m_own = 0; m_dev = 1'b0;
      e_gnt_a = 1'b0; e_gnt_b = 1'b0; e_fcs = 1'b1; e_scs = 1'b1;
      x_live = 1'b0;
    end else begin
      bz = x_live && (c > x_t0) && (c <= x_t0 + 16 * D);
      case (m_phase)
        0: begin
          if (req_a) begin
            m_own = 1; m_dev = dev_a; e_gnt_a = 1'b1; m_phase = 1;
          end else if (req_b) begin
            m_own = 2; m_dev = dev_b; e_gnt_b = 1'b1; m_phase = 1;
          end
        end
        1: begin
          rq = (m_own == 1) ? req_a : req_b;
          cx = (m_own == 1) ? cs_a : cs_b;
          st = (m_own == 1) ? start_a : start_b;
          if (!rq && !bz) begin
            m_phase = 2; e_fcs = 1'b1; e_scs = 1'b1;
          end else begin
            e_fcs = !(cx && !m_dev);
            e_scs = !(cx && m_dev);
          end
          if (rq && st && !bz) begin
            x_live = 1'b1; x_t0 = c; x_who = m_own;
            x_tx = (m_own == 1) ? txd_a : txd_b;
            x_rx = loop ? x_tx : 8'h00;
          end
        end
        default: begin
          m_phase = 0; m_own = 0; e_gnt_a = 1'b0; e_gnt_b = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int k, rel;
    bit e_busy, e_sclk, e_mosi, e_da, e_db, low_now, e_led;
    k = cyc;
    if (done_a) done_a_cnt++;
    if (done_b) done_b_cnt++;
    if (!rst_n) begin
      m_rxd = 8'h00;
      prev_low = -1000;
      chk_reset("rst");
    end else begin
      e_busy = 1'b0; e_sclk = 1'b0; e_mosi = 1'b1; e_da = 1'b0; e_db = 1'b0;
      if (x_live) begin
        rel = k - x_t0 - 1;
        if (rel >= 0 && rel < 16 * D) begin
          e_busy = 1'b1;
          e_sclk = ((rel / D) % 2) == 1;
          e_mosi = x_tx[7 - rel / (2 * D)];
        end else if (rel == 16 * D) begin
          e_da = (x_who == 1);
          e_db = (x_who == 2);
          m_rxd = x_rx;
        end
      end
      low_now = !e_fcs || !e_scs;
      e_led = STRETCH ? ((k - prev_low) <= LED_MAX) : low_now;
      if (low_now) prev_low = k;
      chk("m_gnt", {gnt_a, gnt_b}, {e_gnt_a, e_gnt_b});
      chk("m_cs_n", {flash_cs_n, sd_cs_n}, {e_fcs, e_scs});
      chk("m_busy", busy, e_busy);
      chk("m_sclk", spi_clk, e_sclk);
      chk("m_mosi", spi_mosi, e_mosi);
      chk("m_done", {done_a, done_b}, {e_da, e_db});
      chk("m_rxd", rxd, m_rxd);
      chk("m_led", testled, e_led);
    end
  end

  task automatic wait_for(input int which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      case (which)
        0: seen = gnt_a;
        1: seen = gnt_b;
        2: seen = done_a;
        default: seen = done_b;
      endcase
      if (seen) break;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, d0, d1, n;
    bit mosi0, busy_seen;
    repeat (3) @(negedge clk);
    chk_reset("init");
    #2 rst_n = 1'b1;
    @(negedge clk);

    req_a = 1'b1; req_b = 1'b1; dev_a = 1'b0; dev_b = 1'b1; cs_a = 1'b1; cs_b = 1'b1;
    wait_for(0, "gnt_a_wait");
    chk("gnt_b_blocked", gnt_b, 0);
    repeat (2) @(negedge clk);
    chk("a_flash_cs", {flash_cs_n, sd_cs_n}, 2'b01);
    r0 = rises; txd_a = 8'hA5; start_a = 1'b1; t0 = cyc;
    @(negedge clk); start_a = 1'b0;
    wait_for(2, "done_a_wait");
    chk("a_latency", cyc - t0, 33);
    chk("a_sclk_pulses", rises - r0, 8);
    chk("a_rxd", rxd, 8'hA5);

    @(negedge clk); req_a = 1'b0;
    @(negedge clk);
    chk("a_rel_cs", {flash_cs_n, sd_cs_n}, 2'b11);
    chk("a_rel_gnt_held", gnt_a, 1);
    @(negedge clk);
    chk("a_rel_gnt_drop", {gnt_a, gnt_b}, 2'b00);
    @(negedge clk);
    chk("b_granted", gnt_b, 1);
    @(negedge clk);
    chk("b_sd_cs", {flash_cs_n, sd_cs_n}, 2'b10);

    d0 = done_a_cnt; txd_a = 8'h3C; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    mosi0 = 1'b0; busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!spi_mosi) mosi0 = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    chk("nonowner_no_done", done_a_cnt - d0, 0);
    chk("nonowner_mosi_idle", mosi0, 0);
    chk("nonowner_no_busy", busy_seen, 0);

    loop = 1'b0; txd_b = 8'hFF; start_b = 1'b1; t0 = cyc;
    @(negedge clk); start_b = 1'b0;
    wait_for(3, "done_b_wait1");
    chk("b_latency", cyc - t0, 33);
    chk("b_rxd_zero", rxd, 8'h00);
    loop = 1'b1;
    @(negedge clk); txd_b = 8'h96; start_b = 1'b1; t0 = cyc;
    @(negedge clk); start_b = 1'b0;
    repeat (15) @(negedge clk);
    req_b = 1'b0; req_a = 1'b1;
    wait_for(3, "done_b_wait2");
    chk("b2_latency", cyc - t0, 33);
    chk("b2_rxd", rxd, 8'h96);
    @(negedge clk);
    chk("b_rel_cs", {flash_cs_n, sd_cs_n}, 2'b11);
    chk("b_rel_gnt_held", {gnt_a, gnt_b}, 2'b01);
    @(negedge clk);
    chk("b_rel_gnt_drop", {gnt_a, gnt_b}, 2'b00);
    @(negedge clk);
    chk("a_after_b", {gnt_a, gnt_b}, 2'b10);

    repeat (2) @(negedge clk);
    txd_a = 8'h5A; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_byte");
    req_a = 1'b0; cs_a = 1'b0;
    d0 = done_a_cnt; d1 = done_b_cnt;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_done", (done_a_cnt - d0) + (done_b_cnt - d1), 0);

    req_a = 1'b1; cs_a = 1'b1; dev_a = 1'b0;
    wait_for(0, "gnt_a_led");
    repeat (3) @(negedge clk);
    chk("led_on", testled, 1);
    cs_a = 1'b0; n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!testled) break;
      n++;
    end
    chk("led_hold", n, EXP_HOLD);
    req_a = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
